// File: rtl/audio_sample_serializer.sv
// Left-justified stereo DAC serializer: one 16-bit holding buffer per channel, loaded into the frame at each 32-slot wrap.
// Latency: a sample accepted during frame N is shifted out in frame N+1; ready drops while a buffer is full, and an empty buffer repeats the last sample.
module audio_sample_serializer #(
   parameter int BCLK_HALF = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] sample_data_l,
   input  logic        sample_valid_l,
   output logic        left_chan_ready,
   input  logic [15:0] sample_data_r,
   input  logic        sample_valid_r,
   output logic        right_chan_ready,
   output logic        AUD_BCLK,
   output logic        AUD_LRCK,
   output logic        AUD_DACDAT,
   output logic [7:0]  underrun_count
);

   localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

   logic [7:0]  div_cnt;
   logic [4:0]  bit_cnt;
   logic [4:0]  bit_next;
   logic        bclk;
   logic        dacdat;
   logic [31:0] frame_word;
   logic [31:0] frame_next;
   logic [15:0] buf_l;
   logic [15:0] buf_r;
   logic [15:0] last_l;
   logic [15:0] last_r;
   logic [15:0] word_l;
   logic [15:0] word_r;
   logic        full_l;
   logic        full_r;
   logic        toggle;
   logic        fall;
   logic        frame_load;
   logic        accept_l;
   logic        accept_r;
   logic        underrun;

   assign toggle     = (div_cnt == DIV_LAST);
   assign fall       = toggle & bclk;
   assign frame_load = fall & (bit_cnt == 5'd31);
   assign bit_next   = bit_cnt + 5'd1;

   assign left_chan_ready  = ~full_l;
   assign right_chan_ready = ~full_r;
   assign accept_l = sample_valid_l & ~full_l;
   assign accept_r = sample_valid_r & ~full_r;

   // An empty buffer at load time repeats the previous sample; a sample
   // arriving in the load cycle itself is kept for the following frame.
   assign word_l     = full_l ? buf_l : last_l;
   assign word_r     = full_r ? buf_r : last_r;
   assign frame_next = {word_l, word_r};
   assign underrun   = ~full_l | ~full_r;

   assign AUD_BCLK   = bclk;
   assign AUD_LRCK   = bit_cnt[4];
   assign AUD_DACDAT = dacdat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
         bit_cnt <= '0;
      end else begin
         if (toggle) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
         if (fall) begin
            bit_cnt <= bit_next;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_word <= '0;
         last_l     <= '0;
         last_r     <= '0;
         dacdat     <= 1'b0;
      end else if (frame_load) begin
         frame_word <= frame_next;
         last_l     <= word_l;
         last_r     <= word_r;
         dacdat     <= frame_next[31];
      end else if (fall) begin
         dacdat <= frame_word[5'd31 - bit_next];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_l  <= '0;
         buf_r  <= '0;
         full_l <= 1'b0;
         full_r <= 1'b0;
      end else begin
         if (accept_l) begin
            buf_l  <= sample_data_l;
            full_l <= 1'b1;
         end else if (frame_load) begin
            full_l <= 1'b0;
         end
         if (accept_r) begin
            buf_r  <= sample_data_r;
            full_r <= 1'b1;
         end else if (frame_load) begin
            full_r <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         underrun_count <= '0;
      end else if (frame_load && underrun && (underrun_count != 8'hFF)) begin
         underrun_count <= underrun_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_audio_sample_serializer.sv
// Directed bench: default-rate instance for framing/handshake/reset, fast-rate instance for counter saturation.
module tb_audio_sample_serializer;

   logic        clk = 1'b0;
   always #10 clk = ~clk;

   logic        reset;
   logic [15:0] sample_data_l;
   logic        sample_valid_l;
   logic        left_chan_ready;
   logic [15:0] sample_data_r;
   logic        sample_valid_r;
   logic        right_chan_ready;
   logic        AUD_BCLK;
   logic        AUD_LRCK;
   logic        AUD_DACDAT;
   logic [7:0]  underrun_count;

   logic        reset2;
   logic [15:0] d2_data_l;
   logic        d2_valid_l;
   logic        d2_ready_l;
   logic [15:0] d2_data_r;
   logic        d2_valid_r;
   logic        d2_ready_r;
   logic        d2_bclk;
   logic        d2_lrck;
   logic        d2_dacdat;
   logic [7:0]  d2_underrun;

   int cyc;
   int cyc2;
   int n_cmp;
   int n_bad;

   audio_sample_serializer dut (
      .clk              (clk),
      .reset            (reset),
      .sample_data_l    (sample_data_l),
      .sample_valid_l   (sample_valid_l),
      .left_chan_ready  (left_chan_ready),
      .sample_data_r    (sample_data_r),
      .sample_valid_r   (sample_valid_r),
      .right_chan_ready (right_chan_ready),
      .AUD_BCLK         (AUD_BCLK),
      .AUD_LRCK         (AUD_LRCK),
      .AUD_DACDAT       (AUD_DACDAT),
      .underrun_count   (underrun_count)
   );

   audio_sample_serializer #(.BCLK_HALF(2)) dut2 (
      .clk              (clk),
      .reset            (reset2),
      .sample_data_l    (d2_data_l),
      .sample_valid_l   (d2_valid_l),
      .left_chan_ready  (d2_ready_l),
      .sample_data_r    (d2_data_r),
      .sample_valid_r   (d2_valid_r),
      .right_chan_ready (d2_ready_r),
      .AUD_BCLK         (d2_bclk),
      .AUD_LRCK         (d2_lrck),
      .AUD_DACDAT       (d2_dacdat),
      .underrun_count   (d2_underrun)
   );

   always @(posedge clk) begin
      if (reset2) cyc2 <= 0;
      else        cyc2 <= cyc2 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
      cyc += n;
   endtask

   task automatic wait_until(input int c);
      if (c > cyc) step(c - cyc);
   endtask

   task automatic send(input bit right, input logic [15:0] d);
      if (!right) begin
         chk("ready_l_before_send", 32'(left_chan_ready), 32'd1);
         sample_data_l  = d;
         sample_valid_l = 1'b1;
         step(1);
         sample_valid_l = 1'b0;
         chk("ready_l_after_send", 32'(left_chan_ready), 32'd0);
      end else begin
         chk("ready_r_before_send", 32'(right_chan_ready), 32'd1);
         sample_data_r  = d;
         sample_valid_r = 1'b1;
         step(1);
         sample_valid_r = 1'b0;
         chk("ready_r_after_send", 32'(right_chan_ready), 32'd0);
      end
   endtask

   // Bit k of a frame is driven at the k-th BCLK fall after the load cycle.
   task automatic check_frame(input int base, input logic [31:0] w);
      for (int k = 0; k < 32; k++) begin
         wait_until(base + 32 * k);
         chk($sformatf("dacdat_frame%0d_bit%0d", base, k), 32'(AUD_DACDAT), 32'(w[31 - k]));
         chk($sformatf("lrck_frame%0d_bit%0d", base, k), 32'(AUD_LRCK), 32'(k >= 16));
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      cyc   = 0;
      reset = 1'b1;
      reset2 = 1'b1;
      sample_data_l  = '0;
      sample_valid_l = 1'b0;
      sample_data_r  = '0;
      sample_valid_r = 1'b0;
      d2_data_l  = '0;
      d2_valid_l = 1'b0;
      d2_data_r  = '0;
      d2_valid_r = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      reset2 = 1'b0;
      cyc    = 0;

      // Reset state and free-running timing with no samples offered.
      chk("rst_bclk", 32'(AUD_BCLK), 32'd0);
      chk("rst_lrck", 32'(AUD_LRCK), 32'd0);
      chk("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
      chk("rst_underrun", 32'(underrun_count), 32'd0);
      chk("rst_ready_l", 32'(left_chan_ready), 32'd1);
      chk("rst_ready_r", 32'(right_chan_ready), 32'd1);
      wait_until(15);   chk("bclk_c15", 32'(AUD_BCLK), 32'd0);
      wait_until(16);   chk("bclk_c16", 32'(AUD_BCLK), 32'd1);
      wait_until(31);   chk("bclk_c31", 32'(AUD_BCLK), 32'd1);
      wait_until(32);   chk("bclk_c32", 32'(AUD_BCLK), 32'd0);
      wait_until(511);  chk("lrck_c511", 32'(AUD_LRCK), 32'd0);
      wait_until(512);  chk("lrck_c512", 32'(AUD_LRCK), 32'd1);
      wait_until(600);  chk("dacdat_c600", 32'(AUD_DACDAT), 32'd0);
      wait_until(1023);
      chk("underrun_c1023", 32'(underrun_count), 32'd0);
      chk("dacdat_c1023", 32'(AUD_DACDAT), 32'd0);
      wait_until(1024);
      chk("underrun_c1024", 32'(underrun_count), 32'd1);
      chk("lrck_c1024", 32'(AUD_LRCK), 32'd0);
      chk("fast_underrun_c1024", 32'(d2_underrun), 32'd8);

      // Both channels supplied, then a second left sample held against a full buffer.
      wait_until(1100);
      send(1'b0, 16'hA5F0);
      send(1'b1, 16'h0F0F);
      wait_until(1200);
      sample_data_l  = 16'h1234;
      sample_valid_l = 1'b1;
      chk("ready_l_full_c1200", 32'(left_chan_ready), 32'd0);
      wait_until(2047);
      chk("ready_l_full_c2047", 32'(left_chan_ready), 32'd0);
      chk("dacdat_c2047", 32'(AUD_DACDAT), 32'd0);
      wait_until(2048);
      chk("ready_l_after_load", 32'(left_chan_ready), 32'd1);
      chk("ready_r_after_load", 32'(right_chan_ready), 32'd1);
      chk("underrun_c2048", 32'(underrun_count), 32'd1);
      step(1);
      chk("ready_l_held_accepted", 32'(left_chan_ready), 32'd0);
      sample_valid_l = 1'b0;
      check_frame(2048, 32'hA5F00F0F);

      // Right channel underruns: repeats 0x0F0F beside the held 0x1234.
      wait_until(3072);
      chk("underrun_c3072", 32'(underrun_count), 32'd2);
      check_frame(3072, 32'h12340F0F);
      send(1'b0, 16'h7FFF);
      send(1'b1, 16'h8001);
      wait_until(4096);
      chk("underrun_c4096", 32'(underrun_count), 32'd2);
      check_frame(4096, 32'h7FFF8001);

      // Only right supplied: left slots repeat 0x7FFF.
      send(1'b1, 16'h5555);
      wait_until(5120);
      chk("underrun_c5120", 32'(underrun_count), 32'd3);
      check_frame(5120, 32'h7FFF5555);

      // Handshake landing exactly on the load cycle stays for the next frame.
      wait_until(6143);
      chk("ready_r_c6143", 32'(right_chan_ready), 32'd1);
      sample_data_r  = 16'h0FF0;
      sample_valid_r = 1'b1;
      step(1);
      sample_valid_r = 1'b0;
      chk("ready_r_kept_c6144", 32'(right_chan_ready), 32'd0);
      chk("ready_l_c6144", 32'(left_chan_ready), 32'd1);
      chk("underrun_both_c6144", 32'(underrun_count), 32'd4);
      check_frame(6144, 32'h7FFF5555);
      wait_until(7168);
      chk("underrun_c7168", 32'(underrun_count), 32'd5);
      chk("ready_r_c7168", 32'(right_chan_ready), 32'd1);
      check_frame(7168, 32'h7FFF0FF0);
      wait_until(8192);
      chk("underrun_c8192", 32'(underrun_count), 32'd6);
      wait_until(8200);
      send(1'b0, 16'hBEEF);

      // Reset at bit slot 20 clears everything asynchronously.
      wait_until(8852);
      chk("pre_rst_lrck", 32'(AUD_LRCK), 32'd1);
      chk("pre_rst_bclk", 32'(AUD_BCLK), 32'd1);
      chk("pre_rst_dacdat", 32'(AUD_DACDAT), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst_bclk", 32'(AUD_BCLK), 32'd0);
      chk("async_rst_lrck", 32'(AUD_LRCK), 32'd0);
      chk("async_rst_dacdat", 32'(AUD_DACDAT), 32'd0);
      chk("async_rst_underrun", 32'(underrun_count), 32'd0);
      chk("async_rst_ready_l", 32'(left_chan_ready), 32'd1);
      chk("async_rst_ready_r", 32'(right_chan_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
      check_frame(0, 32'h00000000);
      wait_until(1023);
      chk("rel_underrun_c1023", 32'(underrun_count), 32'd0);
      wait_until(1024);
      chk("rel_underrun_c1024", 32'(underrun_count), 32'd1);
      chk("rel_dacdat_c1024", 32'(AUD_DACDAT), 32'd0);

      // Saturation on the fast instance: 128 clk per frame.
      do begin @(posedge clk); #1; end while (cyc2 < 32639);
      chk("fast_underrun_254", 32'(d2_underrun), 32'd254);
      do begin @(posedge clk); #1; end while (cyc2 < 32640);
      chk("fast_underrun_255", 32'(d2_underrun), 32'd255);
      do begin @(posedge clk); #1; end while (cyc2 < 38528);
      chk("fast_underrun_sat", 32'(d2_underrun), 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
